// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS frequency-sweep sequencer.
package dds_pkg;

    localparam int unsigned DEF_WIDE_N  = 12;
    localparam int unsigned DEF_DWELL_W = 16;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    typedef enum logic [1:0] {
        MODE_SINGLE   = 2'd0,
        MODE_LOOP     = 2'd1,
        MODE_PINGPONG = 2'd2
    } mode_e;

    // Reserved encoding 3 falls back to a single sweep.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_LOOP;
            2'd2:    return MODE_PINGPONG;
            default: return MODE_SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/dds_step_calc.sv
// One sweep step: add/sub in WIDE_N+1 bits, clamp at the target word, flag arrival.
module dds_step_calc
    import dds_pkg::*;
#(
    parameter int unsigned WIDE_N = DEF_WIDE_N
) (
    input  logic [WIDE_N-1:0] fw,
    input  logic [WIDE_N-1:0] step,
    input  logic [WIDE_N-1:0] stop,
    input  logic              dir,
    output logic [WIDE_N-1:0] nxt,
    output logic              at_end
);

    logic [WIDE_N:0] sum;
    logic            past;

    // Carry/borrow out means the word left the representable range.
    always_comb begin
        sum  = '0;
        past = 1'b0;
        if (dir) begin
            sum  = {1'b0, fw} + {1'b0, step};
            past = sum[WIDE_N] || (sum[WIDE_N-1:0] >= stop);
        end else begin
            sum  = {1'b0, fw} - {1'b0, step};
            past = sum[WIDE_N] || (sum[WIDE_N-1:0] <= stop);
        end
        nxt    = past ? stop : sum[WIDE_N-1:0];
        at_end = (fw == stop);
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer feeding the DDS accumulator's frequency word.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned WIDE_N  = DEF_WIDE_N,
    parameter int unsigned DWELL_W = DEF_DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [WIDE_N-1:0]  cfg_start_fw,
    input  logic [WIDE_N-1:0]  cfg_stop_fw,
    input  logic [WIDE_N-1:0]  cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic               abort,
    output logic [WIDE_N-1:0]  fw_o,
    output logic               step_stb,
    output logic               busy,
    output logic               done
);

    state_e             state;
    mode_e              mode_q;
    logic [WIDE_N-1:0]  start_q;
    logic [WIDE_N-1:0]  stop_q;
    logic [WIDE_N-1:0]  step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               dir_q;

    logic [WIDE_N-1:0]  nxt_fwd;
    logic [WIDE_N-1:0]  nxt_rev;
    logic               at_end;
    logic               at_start;
    logic               degen;

    // Forward step toward the current stop word.
    dds_step_calc #(.WIDE_N(WIDE_N)) u_calc_fwd (
        .fw     (fw_o),
        .step   (step_q),
        .stop   (stop_q),
        .dir    (dir_q),
        .nxt    (nxt_fwd),
        .at_end (at_end)
    );

    // Reverse step used for the ping-pong turnaround.
    dds_step_calc #(.WIDE_N(WIDE_N)) u_calc_rev (
        .fw     (fw_o),
        .step   (step_q),
        .stop   (start_q),
        .dir    (~dir_q),
        .nxt    (nxt_rev),
        .at_end (at_start)
    );

    // Sitting on both endpoints at once means start==stop.
    assign degen     = (step_q == '0) || (at_end && at_start);
    assign cfg_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= MODE_SINGLE;
            start_q   <= '0;
            stop_q    <= '0;
            step_q    <= '0;
            dwell_q   <= '0;
            dwell_cnt <= '0;
            dir_q     <= 1'b1;
            fw_o      <= '0;
            step_stb  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            step_stb <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        state     <= RUN;
                        mode_q    <= decode_mode(cfg_mode);
                        start_q   <= cfg_start_fw;
                        stop_q    <= cfg_stop_fw;
                        step_q    <= cfg_step;
                        dwell_q   <= cfg_dwell;
                        dwell_cnt <= cfg_dwell;
                        dir_q     <= (cfg_stop_fw >= cfg_start_fw);
                        fw_o      <= cfg_start_fw;
                        step_stb  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end else if (degen) begin
                        // Repeating modes park on the start word until aborted.
                        if (mode_q == MODE_SINGLE) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else if (at_end) begin
                        case (mode_q)
                            MODE_LOOP: begin
                                fw_o      <= start_q;
                                step_stb  <= 1'b1;
                                dwell_cnt <= dwell_q;
                            end
                            MODE_PINGPONG: begin
                                start_q   <= stop_q;
                                stop_q    <= start_q;
                                dir_q     <= ~dir_q;
                                fw_o      <= nxt_rev;
                                step_stb  <= 1'b1;
                                dwell_cnt <= dwell_q;
                            end
                            default: begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        endcase
                    end else begin
                        fw_o      <= nxt_fwd;
                        step_stb  <= 1'b1;
                        dwell_cnt <= dwell_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed and randomized sweeps checked against a word-list model of the sequencer.
module tb_dds_sweep_ctrl;

    localparam int unsigned WIDE_N  = 12;
    localparam int unsigned DWELL_W = 16;
    localparam int          SEQ_LIM = 200;
    localparam int          NO_ABORT = -1;
    localparam int          BIG = 1 << 20;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [WIDE_N-1:0]  cfg_start_fw = '0;
    logic [WIDE_N-1:0]  cfg_stop_fw = '0;
    logic [WIDE_N-1:0]  cfg_step = '0;
    logic [DWELL_W-1:0] cfg_dwell = '0;
    logic [1:0]         cfg_mode = '0;
    logic               abort = 1'b0;
    logic [WIDE_N-1:0]  fw_o;
    logic               step_stb;
    logic               busy;
    logic               done;

    int tests = 0;
    int fails = 0;

    int seq[$];
    bit degen_m;
    int mode_m;

    dds_sweep_ctrl #(.WIDE_N(WIDE_N), .DWELL_W(DWELL_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_start_fw (cfg_start_fw),
        .cfg_stop_fw  (cfg_stop_fw),
        .cfg_step     (cfg_step),
        .cfg_dwell    (cfg_dwell),
        .cfg_mode     (cfg_mode),
        .abort        (abort),
        .fw_o         (fw_o),
        .step_stb     (step_stb),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Next word of a sweep heading toward tgt, clamped and never wrapping.
    function automatic int step_to(input int v, input int tgt, input int step, input bit up);
        int n;
        if (up) begin
            n = v + step;
            if (n >= tgt || n > 4095) n = tgt;
        end else begin
            n = v - step;
            if (n <= tgt || n < 0) n = tgt;
        end
        return n;
    endfunction

    // Full list of words the sweep should present, one entry per word.
    task automatic build(input int start, input int stop, input int step, input int mode);
        int v;
        int a;
        int b;
        int t;
        bit up;
        seq.delete();
        mode_m  = (mode == 3) ? 0 : mode;
        degen_m = (start == stop) || (step == 0);
        seq.push_back(start);
        if (degen_m) return;
        up = (stop >= start);
        v  = start;
        a  = start;
        b  = stop;
        if (mode_m == 0) begin
            while (v != stop) begin
                v = step_to(v, stop, step, up);
                seq.push_back(v);
            end
        end else if (mode_m == 1) begin
            while (seq.size() < SEQ_LIM) begin
                v = (v == stop) ? start : step_to(v, stop, step, up);
                seq.push_back(v);
            end
        end else begin
            while (seq.size() < SEQ_LIM) begin
                if (v == b) begin
                    t  = a;
                    a  = b;
                    b  = t;
                    up = !up;
                end
                v = step_to(v, b, step, up);
                seq.push_back(v);
            end
        end
    endtask

    task automatic present(input int start, input int stop, input int step, input int dwell,
                           input int mode);
        cfg_start_fw = WIDE_N'(start);
        cfg_stop_fw  = WIDE_N'(stop);
        cfg_step     = WIDE_N'(step);
        cfg_dwell    = DWELL_W'(dwell);
        cfg_mode     = 2'(mode);
    endtask

    task automatic accept(input int start, input int stop, input int step, input int dwell,
                          input int mode, input bit with_abort);
        check("cfg_ready_idle", 32'(cfg_ready), 1);
        present(start, stop, step, dwell, mode);
        build(start, stop, step, mode);
        cfg_valid = 1'b1;
        abort     = with_abort;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        abort     = 1'b0;
    endtask

    // Checks every cycle from the accept edge onward; entered at sample k=0.
    task automatic follow(input int dwell, input int max_k, input int abort_k, input bit tail);
        int total;
        int efw;
        int estb;
        total = seq.size() * (dwell + 1);
        for (int k = 0; k < max_k; k++) begin
            if (mode_m == 0 && k == total) begin
                check("done_pulse", 32'(done), 1);
                check("busy_end", 32'(busy), 0);
                check("fw_end", 32'(fw_o), 32'(seq[seq.size()-1]));
                check("stb_end", 32'(step_stb), 0);
                check("ready_end", 32'(cfg_ready), 1);
                if (tail) begin
                    @(posedge clk);
                    #1;
                    check("done_once", 32'(done), 0);
                    check("busy_after", 32'(busy), 0);
                    check("fw_hold", 32'(fw_o), 32'(seq[seq.size()-1]));
                end
                return;
            end
            if (degen_m && mode_m != 0) begin
                efw  = seq[0];
                estb = (k == 0) ? 1 : 0;
            end else begin
                efw  = seq[k / (dwell + 1)];
                estb = ((k % (dwell + 1)) == 0) ? 1 : 0;
            end
            check("fw", 32'(fw_o), 32'(efw));
            check("stb", 32'(step_stb), 32'(estb));
            check("busy", 32'(busy), 1);
            check("done_low", 32'(done), 0);
            check("ready_busy", 32'(cfg_ready), 0);
            if (k == abort_k) begin
                abort = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
                check("abort_busy", 32'(busy), 0);
                check("abort_done", 32'(done), 0);
                check("abort_fw", 32'(fw_o), 32'(efw));
                check("abort_stb", 32'(step_stb), 0);
                check("abort_ready", 32'(cfg_ready), 1);
                @(posedge clk);
                #1;
                check("abort_done2", 32'(done), 0);
                check("abort_fw2", 32'(fw_o), 32'(efw));
                return;
            end
            if (k < max_k - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        int s;
        int e;
        int st;
        int dw;
        int md;
        int ak;

        repeat (2) @(posedge clk);
        #1;
        check("rst_fw", 32'(fw_o), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_stb", 32'(step_stb), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ready", 32'(cfg_ready), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single up sweep
        accept(100, 130, 10, 2, 0, 1'b0);
        follow(2, BIG, NO_ABORT, 1'b1);

        // Clamp on the stop word, and clamp instead of wrapping past 4095
        accept(0, 25, 10, 0, 0, 1'b0);
        follow(0, BIG, NO_ABORT, 1'b1);
        accept(4090, 4095, 10, 0, 0, 1'b0);
        follow(0, BIG, NO_ABORT, 1'b1);
        accept(5, 0, 10, 1, 0, 1'b0);
        follow(1, BIG, NO_ABORT, 1'b1);

        // Down sweep
        accept(4000, 3990, 6, 1, 0, 1'b0);
        follow(1, BIG, NO_ABORT, 1'b1);

        // Ping-pong, aborted while showing the seventh word
        accept(10, 30, 10, 0, 2, 1'b0);
        follow(0, 150, 6, 1'b0);

        // Loop mode wraps back to start
        accept(50, 80, 15, 1, 1, 1'b0);
        follow(1, 40, 30, 1'b0);

        // Degenerate configurations
        accept(700, 900, 0, 3, 0, 1'b0);
        follow(3, BIG, NO_ABORT, 1'b1);
        accept(333, 333, 5, 2, 0, 1'b0);
        follow(2, BIG, NO_ABORT, 1'b1);
        accept(700, 900, 0, 1, 2, 1'b0);
        follow(1, 20, 15, 1'b0);
        accept(42, 42, 7, 0, 1, 1'b0);
        follow(0, 20, 12, 1'b0);

        // Reserved mode behaves as single
        accept(20, 50, 10, 0, 3, 1'b0);
        follow(0, BIG, NO_ABORT, 1'b1);

        // Abort landing on the completion edge suppresses done
        accept(100, 130, 10, 0, 0, 1'b0);
        follow(0, BIG, 3, 1'b0);

        // Abort in IDLE is ignored and a same-cycle offer is still taken
        accept(1000, 1040, 20, 0, 0, 1'b1);
        follow(0, BIG, NO_ABORT, 1'b1);

        // Offer held during a sweep is taken on the first IDLE cycle
        accept(200, 210, 10, 0, 0, 1'b0);
        present(500, 520, 20, 1, 0);
        cfg_valid = 1'b1;
        follow(0, BIG, NO_ABORT, 1'b0);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        build(500, 520, 20, 0);
        follow(1, BIG, NO_ABORT, 1'b1);

        // Asynchronous reset during the second word
        accept(300, 400, 20, 3, 0, 1'b0);
        follow(3, 6, NO_ABORT, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_fw", 32'(fw_o), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_ready", 32'(cfg_ready), 1);
        check("arst_done", 32'(done), 0);
        check("arst_stb", 32'(step_stb), 0);
        @(posedge clk);
        #1;
        check("arst_hold_fw", 32'(fw_o), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        accept(1500, 1460, 15, 0, 0, 1'b0);
        follow(0, BIG, NO_ABORT, 1'b1);

        // Randomized configurations
        for (int i = 0; i < 14; i++) begin
            s = int'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) == 0) begin
                e = s + int'($urandom_range(0, 3));
                if (e > 4095) e = 4095;
            end else begin
                e = int'($urandom_range(0, 4095));
            end
            st = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(40, 1500));
            dw = int'($urandom_range(0, 3));
            md = int'($urandom_range(0, 3));
            accept(s, e, st, dw, md, 1'b0);
            if (md == 1 || md == 2) begin
                ak = int'($urandom_range(0, 120));
                follow(dw, 150, ak, 1'b0);
            end else if ($urandom_range(0, 2) == 0) begin
                ak = int'($urandom_range(0, seq.size() * (dw + 1) - 1));
                follow(dw, BIG, ak, 1'b0);
            end else begin
                follow(dw, BIG, NO_ABORT, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
